// File: rtl/register_f_flag_reader_if.sv
// ---------------------------------------------------------------------------
// register_f_flag_reader_if
// Purpose : bundles the flag inputs, the sequencer request and the decision
//           outputs of register_f_flag_reader into one port.
// Signals :
//   f_s, f_z, f_pv, f_c  registered S/Z/PV/C flags from register F
//   start                1-cycle request from the sequencer
//   kind[1:0]            00 cond code, 01 LD rpt, 10 CP rpt, 11 IN/OT rpt
//   cc[2:0]              condition code (NZ,Z,NC,C,PO,PE,P,M)
//   abort                flush request, wins over start
//   busy                 high whenever the reader is not idle
//   done                 1-cycle pulse, decision valid
//   taken                decision, held until the next done
//   pc_rewind            1-cycle pulse with done when a block op repeats
//   repeat_count         repeated iterations of the current block op
// Modports: master = sequencer / flag side, slave = the flag reader.
// ---------------------------------------------------------------------------
interface register_f_flag_reader_if #(
  parameter int COUNT_W = 16
);
  logic               f_s;
  logic               f_z;
  logic               f_pv;
  logic               f_c;
  logic               start;
  logic [1:0]         kind;
  logic [2:0]         cc;
  logic               abort;
  logic               busy;
  logic               done;
  logic               taken;
  logic               pc_rewind;
  logic [COUNT_W-1:0] repeat_count;

  modport master (
    output f_s, f_z, f_pv, f_c, start, kind, cc, abort,
    input  busy, done, taken, pc_rewind, repeat_count
  );

  modport slave (
    input  f_s, f_z, f_pv, f_c, start, kind, cc, abort,
    output busy, done, taken, pc_rewind, repeat_count
  );
endinterface

// File: rtl/register_f_flag_reader.sv
// ---------------------------------------------------------------------------
// register_f_flag_reader
// Purpose : consumer side of the F flag register. On a sequencer request it
//           waits SETTLE_CYCLES, samples S/Z/PV/C and returns either a
//           taken/not-taken decision for the eight condition codes or a
//           repeat/finish decision for block instructions (LDxR, CPxR,
//           INxR, OTxR), with a PC rewind pulse on repeat.
// Parameters:
//   SETTLE_CYCLES  wait cycles between request and flag sample (0..3)
//   COUNT_W        width of the block-repeat iteration counter
// Ports   :
//   i_clk   system clock, rising edge
//   i_rst   asynchronous active-high reset
//   io_bus  register_f_flag_reader_if.slave (flags, request, decision)
// Configuration macro:
//   REGISTER_F_REPEAT_COUNT_EN  defined -> repeat_count counter present;
//                               undefined -> repeat_count tied to 0.
// ---------------------------------------------------------------------------
module register_f_flag_reader #(
  parameter int SETTLE_CYCLES = 1,
  parameter int COUNT_W       = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  register_f_flag_reader_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_EVAL   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Counter load value: the last SETTLE cycle is the one where the count is 0.
  localparam logic [1:0] SETTLE_LOAD = 2'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_settle_cnt;
  logic [1:0] w_settle_next;
  logic       w_latch;
  logic       w_eval;

  logic [1:0] r_kind;
  logic [2:0] r_cc;
  logic       r_taken;
  logic       r_pc_rewind;

  logic [3:0] w_flag_sel;
  logic [7:0] w_cc_table;
  logic       w_is_block;
  logic       w_repeat;
  logic       w_decision;

  // -------------------------------------------------------------------------
  // Condition-code table. Codes come in pairs on the same flag: the even
  // code is the "not set" test, the odd code the "set" test.
  // -------------------------------------------------------------------------
  assign w_flag_sel = {io_bus.f_s, io_bus.f_pv, io_bus.f_c, io_bus.f_z};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cc
      assign w_cc_table[gi] = w_flag_sel[gi / 2] ^ ((gi % 2) == 0);
    end
  endgenerate

  assign w_is_block = (r_kind != 2'b00);

  always_comb begin
    w_repeat = 1'b0;
    case (r_kind)
      2'b01:   w_repeat = io_bus.f_pv;
      2'b10:   w_repeat = io_bus.f_pv & ~io_bus.f_z;
      2'b11:   w_repeat = ~io_bus.f_z;
      default: w_repeat = 1'b0;
    endcase
  end

  assign w_decision = w_is_block ? w_repeat : w_cc_table[r_cc];

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= 2'd0;
    end else begin
      r_state      <= w_state_next;
      r_settle_cnt <= w_settle_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state. Abort overrides everything, including a pending start
  // and the evaluation edge, so no decision state is touched on abort.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_settle_next = r_settle_cnt;
    w_latch       = 1'b0;
    w_eval        = 1'b0;
    if (io_bus.abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            w_latch       = 1'b1;
            w_settle_next = SETTLE_LOAD;
            w_state_next  = (SETTLE_CYCLES == 0) ? S_EVAL : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == 2'd0) begin
            w_state_next = S_EVAL;
          end else begin
            w_settle_next = r_settle_cnt - 2'd1;
          end
        end
        S_EVAL: begin
          w_eval       = 1'b1;
          w_state_next = S_DONE;
        end
        S_DONE: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Request latch and decision registers. The decision is captured on the
  // EVAL -> DONE edge so it is visible together with done.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_kind      <= 2'b00;
      r_cc        <= 3'd0;
      r_taken     <= 1'b0;
      r_pc_rewind <= 1'b0;
    end else begin
      if (w_latch) begin
        r_kind <= io_bus.kind;
        r_cc   <= io_bus.cc;
      end
      if (w_eval) begin
        r_taken <= w_decision;
      end
      r_pc_rewind <= w_eval & w_is_block & w_repeat;
    end
  end

  // -------------------------------------------------------------------------
  // Block-repeat iteration counter
  // -------------------------------------------------------------------------
`ifdef REGISTER_F_REPEAT_COUNT_EN
  logic [COUNT_W-1:0] r_repeat_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_repeat_count <= '0;
    end else if (w_eval && w_is_block) begin
      if (w_repeat) begin
        // Saturate rather than wrap so a long block op never looks fresh.
        if (~&r_repeat_count) begin
          r_repeat_count <= r_repeat_count + COUNT_W'(1);
        end
      end else begin
        r_repeat_count <= '0;
      end
    end
  end

  assign io_bus.repeat_count = r_repeat_count;
`else
  assign io_bus.repeat_count = '0;
`endif

  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.done      = (r_state == S_DONE);
  assign io_bus.taken     = r_taken;
  assign io_bus.pc_rewind = r_pc_rewind;

endmodule

// File: tb/tb_register_f_flag_reader.sv
// ---------------------------------------------------------------------------
// tb_register_f_flag_reader
// Directed scoreboard bench for register_f_flag_reader with SETTLE_CYCLES=1
// and COUNT_W=2 (so counter saturation is reachable). Requests push their
// expected decision and done cycle into a queue; a monitor pops and compares
// whenever done is seen. Expected repeat counts collapse to 0 when the
// REGISTER_F_REPEAT_COUNT_EN macro is undefined.
// ---------------------------------------------------------------------------
module tb_register_f_flag_reader;

  localparam int CW = 2;

  typedef struct packed {
    logic          taken;
    logic          rewind;
    logic [CW-1:0] cnt;
    int            cyc;
  } exp_t;

  typedef struct packed {
    logic [2:0] cc;
    logic [3:0] fl;    // {s, z, pv, c}
    logic       taken;
  } ccvec_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];

  register_f_flag_reader_if #(.COUNT_W(CW)) bus ();

  register_f_flag_reader #(
    .SETTLE_CYCLES(1),
    .COUNT_W      (CW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] cnt_exp(input int c);
`ifdef REGISTER_F_REPEAT_COUNT_EN
    return CW'(c);
`else
    return CW'(c * 0);
`endif
  endfunction

  // One request. fl is presented at start and again during EVAL; fl_mid is
  // presented during SETTLE and must not influence the decision. hold keeps
  // start high while busy to show it is ignored.
  task automatic req(input logic [1:0] k, input logic [2:0] c,
                     input logic [3:0] fl, input logic [3:0] fl_mid,
                     input bit hold, input logic exp_tk, input logic exp_rw,
                     input int exp_c);
    exp_t e;
    @(negedge clk);
    {bus.f_s, bus.f_z, bus.f_pv, bus.f_c} = fl;
    bus.kind  = k;
    bus.cc    = c;
    bus.start = 1'b1;
    e.taken  = exp_tk;
    e.rewind = exp_rw;
    e.cnt    = cnt_exp(exp_c);
    e.cyc    = cyc + 3;
    exp_q.push_back(e);
    @(negedge clk);
    {bus.f_s, bus.f_z, bus.f_pv, bus.f_c} = fl_mid;
    if (!hold) bus.start = 1'b0;
    @(negedge clk);
    {bus.f_s, bus.f_z, bus.f_pv, bus.f_c} = fl;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    $display("req kind=%0d cc=%0d flags=%b exp_taken=%0d exp_rewind=%0d exp_cnt=%0d",
             k, c, fl, exp_tk, exp_rw, e.cnt);
  endtask

  // Monitor: compares every done pulse against the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("taken", int'(bus.taken), int'(e.taken));
            chk("pc_rewind", int'(bus.pc_rewind), int'(e.rewind));
            chk("repeat_count", int'(bus.repeat_count), int'(e.cnt));
            chk("done_cycle", cyc, e.cyc);
            $display("done cyc=%0d taken=%0d rewind=%0d cnt=%0d", cyc, bus.taken,
                     bus.pc_rewind, bus.repeat_count);
          end
        end else begin
          chk("rewind_without_done", int'(bus.pc_rewind), 0);
        end
      end
    end
  end

  ccvec_t ccv[16];

  initial begin
    ccv[0]  = '{3'd0, 4'b1011, 1'b1};
    ccv[1]  = '{3'd0, 4'b0100, 1'b0};
    ccv[2]  = '{3'd1, 4'b0100, 1'b1};
    ccv[3]  = '{3'd1, 4'b1011, 1'b0};
    ccv[4]  = '{3'd2, 4'b1110, 1'b1};
    ccv[5]  = '{3'd2, 4'b0001, 1'b0};
    ccv[6]  = '{3'd3, 4'b0001, 1'b1};
    ccv[7]  = '{3'd3, 4'b1110, 1'b0};
    ccv[8]  = '{3'd4, 4'b1101, 1'b1};
    ccv[9]  = '{3'd4, 4'b0010, 1'b0};
    ccv[10] = '{3'd5, 4'b0010, 1'b1};
    ccv[11] = '{3'd5, 4'b1101, 1'b0};
    ccv[12] = '{3'd6, 4'b0111, 1'b1};
    ccv[13] = '{3'd6, 4'b1000, 1'b0};
    ccv[14] = '{3'd7, 4'b1000, 1'b1};
    ccv[15] = '{3'd7, 4'b0111, 1'b0};

    cyc = 0; n_checks = 0; n_errors = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.kind = 2'b00; bus.cc = 3'd0;
    {bus.f_s, bus.f_z, bus.f_pv, bus.f_c} = 4'b0000;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_taken", int'(bus.taken), 0);
    chk("rst_count", int'(bus.repeat_count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Condition codes, both polarities each
    for (int i = 0; i < 16; i++) begin
      req(2'b00, ccv[i].cc, ccv[i].fl, ccv[i].fl, 1'b0, ccv[i].taken, 1'b0, 0);
    end

    // LD repeat: three repeats then finish
    req(2'b01, 3'd0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 1);
    req(2'b01, 3'd0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 2);
    req(2'b01, 3'd0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 3);
    req(2'b01, 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0);

    // CP / IN-OT repeat rules
    req(2'b10, 3'd0, 4'b0110, 4'b0110, 1'b0, 1'b0, 1'b0, 0);
    req(2'b10, 3'd0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 1);
    req(2'b10, 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0);
    req(2'b11, 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1);
    req(2'b11, 3'd0, 4'b0110, 4'b0110, 1'b0, 1'b0, 1'b0, 0);

    // Saturation at 2-bit all-ones
    req(2'b01, 3'd0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 1);
    req(2'b01, 3'd0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 2);
    req(2'b01, 3'd0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 3);
    req(2'b01, 3'd0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 3);
    req(2'b01, 3'd0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 3);
    req(2'b01, 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0);
    req(2'b01, 3'd0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 1);

    // Abort during EVAL of a request that would finish the block op
    @(negedge clk);
    {bus.f_s, bus.f_z, bus.f_pv, bus.f_c} = 4'b0000;
    bus.kind = 2'b01; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_eval_busy", int'(bus.busy), 0);
    chk("abort_eval_taken_held", int'(bus.taken), 1);
    $display("abort during EVAL busy=%0d taken=%0d", bus.busy, bus.taken);
    // Count resumes from 1 after the abort
    req(2'b01, 3'd0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 2);

    // Start and abort together
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    chk("start_abort_busy", int'(bus.busy), 0);
    $display("start+abort busy=%0d", bus.busy);
    bus.start = 1'b0; bus.abort = 1'b0;

    // Start held while busy: exactly one done (count untouched by cond code)
    req(2'b00, 3'd1, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0, 2);
    repeat (4) @(negedge clk);
    chk("held_start_no_extra", exp_q.size(), 0);

    // Flags toggled during SETTLE are ignored (M with S=0 at EVAL)
    req(2'b00, 3'd7, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 2);

    // Reset mid-SETTLE after a taken repeat
    req(2'b11, 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 3);
    @(negedge clk);
    {bus.f_s, bus.f_z, bus.f_pv, bus.f_c} = 4'b0010;
    bus.kind = 2'b01; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("pre_rst_busy", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_taken", int'(bus.taken), 0);
    chk("midrst_count", int'(bus.repeat_count), 0);
    $display("reset mid-SETTLE busy=%0d taken=%0d cnt=%0d", bus.busy, bus.taken,
             bus.repeat_count);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Normal operation after reset
    req(2'b01, 3'd0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 1);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
